// File: rtl/hpi_pkg.sv
// rtl/hpi_pkg.sv - shared types and constants for the HPI bus arbiter
//
// Purpose: defines the access FSM state type and the HPI register select
// codes, plus the default access timing.
// Ports: none (package).
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_STROBE_CYC  = 2;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_RECOVER_CYC = 2;

  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// rtl/hpi_rr_arbiter.sv - two-way round-robin grant for the HPI arbiter
//
// Purpose: picks one of two requesters; on a tie the port not granted last
// wins. The last-grant memory only moves when the caller commits a grant.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     per-port request
//   update       commit the current grant into the last-grant register
//   grant_valid  at least one port is requesting
//   grant_idx    winning port (0 or 1)
module hpi_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_q, last_d;

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_q;
      default: grant_idx = 1'b0;
    endcase
    last_d = (update && grant_valid) ? grant_idx : last_q;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// rtl/hpi_bus_arbiter.sv - shares the CY7C67200 HPI between two requesters
//
// Purpose: arbitrates port 0 (software) and port 1 (keycode poller) and runs
// each granted request as one timed HPI read or write cycle.
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   req, we                     per-port request level and write select
//   addr0/1, wdata0/1           per-port register select and write data
//   ack                         per-port one-cycle completion pulse
//   rdata0/1                    per-port read data, held until next read ack
//   otg_hpi_*                   registered HPI pins and pad data enable
module hpi_bus_arbiter
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [1:0]  otg_hpi_addr,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in
);

  localparam int MAX_CYC = cyc_max(cyc_max(SETUP_CYC, STROBE_CYC),
                                   cyc_max(HOLD_CYC, RECOVER_CYC));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  // Counter is loaded with N-1 on entry and the state exits when it hits 0.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hpi_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [1:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            cs_n_q, cs_n_d;
  logic            r_n_q, r_n_d;
  logic            w_n_q, w_n_d;
  logic            oe_q, oe_d;
  logic [1:0]      ack_q, ack_d;
  logic [15:0]     rdata0_q, rdata0_d;
  logic [15:0]     rdata1_q, rdata1_d;
  logic            arb_valid, arb_idx, arb_update;
  logic            bus_active;

  hpi_rr_arbiter u_arb (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .req         (req),
    .update      (arb_update),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack_d      = 2'b00;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          gnt_d      = arb_idx;
          we_d       = we[arb_idx];
          addr_d     = arb_idx ? addr1 : addr0;
          wdata_d    = arb_idx ? wdata1 : wdata0;
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Read data is sampled at the edge that ends the strobe.
          if (!we_q) begin
            if (gnt_q) rdata1_d = otg_hpi_data_in;
            else       rdata0_d = otg_hpi_data_in;
          end
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LD;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pins are decoded from the next state so they change on the same edge.
    bus_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                 (state_d == ST_HOLD);
    cs_n_d = ~bus_active;
    oe_d   = bus_active & we_d;
    r_n_d  = ~((state_d == ST_STROBE) & ~we_d);
    w_n_d  = ~((state_d == ST_STROBE) & we_d);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 2'b00;
      wdata_q  <= 16'h0000;
      cs_n_q   <= 1'b1;
      r_n_q    <= 1'b1;
      w_n_q    <= 1'b1;
      oe_q     <= 1'b0;
      ack_q    <= 2'b00;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_n_q   <= cs_n_d;
      r_n_q    <= r_n_d;
      w_n_q    <= w_n_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack              = ack_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign otg_hpi_addr     = addr_q;
  assign otg_hpi_cs_n     = cs_n_q;
  assign otg_hpi_r_n      = r_n_q;
  assign otg_hpi_w_n      = w_n_q;
  assign otg_hpi_data_out = wdata_q;
  assign otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// tb/tb_hpi_bus_arbiter.sv - self-checking bench for hpi_bus_arbiter
module tb_hpi_bus_arbiter;
  import hpi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_b = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [1:0]  addr0 = 2'b00, addr1 = 2'b00;
  logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
  logic [15:0] data_in = 16'h0;

  logic [1:0]  ack, ack_b;
  logic [15:0] rdata0, rdata1, rdata0_b, rdata1_b;
  logic [1:0]  hpi_addr, hpi_addr_b;
  logic        cs_n, r_n, w_n, oe, cs_n_b, r_n_b, w_n_b, oe_b;
  logic [15:0] data_out, data_out_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hpi_bus_arbiter dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata0(rdata0), .rdata1(rdata1), .otg_hpi_addr(hpi_addr),
    .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n), .otg_hpi_w_n(w_n),
    .otg_hpi_data_out(data_out), .otg_hpi_data_oe(oe),
    .otg_hpi_data_in(data_in)
  );

  hpi_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .RECOVER_CYC(1)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .req(req_b), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_b), .rdata0(rdata0_b), .rdata1(rdata1_b), .otg_hpi_addr(hpi_addr_b),
    .otg_hpi_cs_n(cs_n_b), .otg_hpi_r_n(r_n_b), .otg_hpi_w_n(w_n_b),
    .otg_hpi_data_out(data_out_b), .otg_hpi_data_oe(oe_b),
    .otg_hpi_data_in(data_in)
  );

  typedef struct {
    int          port;
    logic        w;
    logic [1:0]  a;
    logic [15:0] wd;
    logic [15:0] din;
    logic [15:0] exp_rd;     // requester's rdata after the access
    logic [15:0] exp_other;  // other port's rdata, must be untouched
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single access on the default-timing instance; cycle 0 is the IDLE cycle
  // in which the request is first seen.
  task automatic run_single(input vec_t v, input string tag);
    logic act, stb;
    @(negedge clk);
    if (v.port == 0) begin addr0 = v.a; wdata0 = v.wd; end
    else             begin addr1 = v.a; wdata1 = v.wd; end
    we[v.port]  = v.w;
    data_in     = v.din;
    req[v.port] = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) data_in = ~v.din;
      act = (c >= 1 && c <= 4);
      stb = (c == 2 || c == 3);
      chk($sformatf("%s c%0d cs_n", tag, c), cs_n, !act);
      chk($sformatf("%s c%0d r_n", tag, c), r_n, !(stb && !v.w));
      chk($sformatf("%s c%0d w_n", tag, c), w_n, !(stb && v.w));
      chk($sformatf("%s c%0d oe", tag, c), oe, act && v.w);
      chk($sformatf("%s c%0d ack", tag, c), ack, (c == 5) ? (2'b01 << v.port) : 2'b00);
      if (act) chk($sformatf("%s c%0d addr", tag, c), hpi_addr, v.a);
      if (act && v.w) chk($sformatf("%s c%0d data_out", tag, c), data_out, v.wd);
      if (c == 5 || c == 7) begin
        chk($sformatf("%s c%0d rdata", tag, c), (v.port == 0) ? rdata0 : rdata1, v.exp_rd);
        chk($sformatf("%s c%0d rdata_other", tag, c), (v.port == 0) ? rdata1 : rdata0, v.exp_other);
      end
      if (c == 5) req = 2'b00;
    end
  endtask

  // Port 0 write on the 3/4/2/1 instance. drop_c is the cycle in which req
  // is released; releasing at 12 keeps req high into the IDLE cycle 11.
  task automatic run_b(input int drop_c, input bit second, input string tag);
    logic act, stb;
    int last_c;
    last_c = second ? 23 : 12;
    @(negedge clk);
    we[0] = 1'b1; addr0 = HPI_MAILBOX; wdata0 = 16'h5A5A; req_b = 2'b01;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      act = (c >= 1 && c <= 9) || (second && c >= 12 && c <= 20);
      stb = (c >= 4 && c <= 7) || (second && c >= 15 && c <= 18);
      chk($sformatf("%s c%0d cs_n", tag, c), cs_n_b, !act);
      chk($sformatf("%s c%0d w_n", tag, c), w_n_b, !stb);
      chk($sformatf("%s c%0d oe", tag, c), oe_b, act);
      chk($sformatf("%s c%0d ack", tag, c), ack_b,
          (c == 10 || (second && c == 21)) ? 2'b01 : 2'b00);
      if (act) chk($sformatf("%s c%0d data_out", tag, c), data_out_b, 16'h5A5A);
      if (c == drop_c) req_b = 2'b00;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, HPI_ADDRESS, 16'h052C, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1, 1'b0, HPI_DATA,    16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[2] = '{0, 1'b0, HPI_STATUS,  16'h0000, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[3] = '{1, 1'b1, HPI_MAILBOX, 16'hA5A5, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[4] = '{1, 1'b0, HPI_ADDRESS, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h1234};

    // Reset state.
    #12;
    chk("rst cs_n", cs_n, 1'b1);
    chk("rst r_n", r_n, 1'b1);
    chk("rst w_n", w_n, 1'b1);
    chk("rst oe", oe, 1'b0);
    chk("rst ack", ack, 2'b00);
    chk("rst addr", hpi_addr, 2'b00);
    chk("rst data_out", data_out, 16'h0);
    chk("rst rdata0", rdata0, 16'h0);
    chk("rst rdata1", rdata1, 16'h0);
    chk("rst b cs_n", cs_n_b, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_single(vecs[i], $sformatf("vec%0d", i));

    // Tie with both requests held: port 0 wins first (last grant was port 1),
    // then strict alternation with a 7-cycle period.
    @(negedge clk);
    we = 2'b01; wdata0 = 16'h3C3C; data_in = 16'h7777; req = 2'b11;
    for (int c = 0; c <= 27; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("alt c%0d ack", c), ack,
          (c == 5 || c == 19) ? 2'b01 : (c == 12 || c == 26) ? 2'b10 : 2'b00);
      if (c == 26) req = 2'b00;
    end

    // Reset during the strobe of a write: pins return to idle at once and no
    // ack appears.
    @(negedge clk);
    we[0] = 1'b1; addr0 = HPI_DATA; wdata0 = 16'h1111; req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("mid w_n before reset", w_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid rst cs_n", cs_n, 1'b1);
    chk("mid rst w_n", w_n, 1'b1);
    chk("mid rst r_n", r_n, 1'b1);
    chk("mid rst oe", oe, 1'b0);
    chk("mid rst addr", hpi_addr, 2'b00);
    chk("mid rst data_out", data_out, 16'h0);
    chk("mid rst rdata1", rdata1, 16'h0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post rst c%0d ack", c), ack, 2'b00);
      chk($sformatf("post rst c%0d cs_n", c), cs_n, 1'b1);
    end
    run_single('{1, 1'b0, HPI_MAILBOX, 16'h0000, 16'hCAFE, 16'hCAFE, 16'h0000}, "after_rst");

    // Non-default timing: release on time, then hold req into IDLE.
    run_b(10, 1'b0, "b_once");
    run_b(12, 1'b1, "b_hold");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hpi_bus_arbiter.md
# hpi_bus_arbiter

Sequences all accesses to the CY7C67200 host port interface (HPI) and shares it between two requesters: the Nios II software path (port 0) and the hardware USB keycode poller (port 1). Each granted request becomes one HPI read or write cycle with programmable setup, strobe, hold and recovery timing. The block sits in the top level between the SoC's HPI-facing exports and the tri-state pad logic for the OTG chip's data bus.

## Interface
Parameters:
- SETUP_CYC, default 1: cycles with CS/address/write data valid before the strobe (≥1).
- STROBE_CYC, default 2: cycles with R_N or W_N low (≥1).
- HOLD_CYC, default 1: cycles with CS/address/data held after the strobe (≥1).
- RECOVER_CYC, default 2: bus-idle cycles after each access (≥1).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- req[1:0]  in  2  per-port request; level, held until ack.
- we[1:0]  in  2  per-port 1 = write, 0 = read.
- addr0, addr1  in  2 each  HPI register select.
- wdata0, wdata1  in  16 each  write data.
- ack[1:0]  out  2  one-cycle completion pulse per port.
- rdata0, rdata1  out  16 each  read data, valid with ack, held until that port's next read ack.
- otg_hpi_addr  out  2  HPI address.
- otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n  out  1 each  active-low strobes.
- otg_hpi_data_out  out  16  drive data.
- otg_hpi_data_oe  out  1  pad output enable.
- otg_hpi_data_in  in  16  pad input data.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter, width $clog2 of the largest parameter + 1, loaded on each state entry.
- IDLE: req sampled here only. One port requesting → grant it. Both requesting → grant the port not granted last. Grant, we, addr and wdata of the winner latched into internal registers → SETUP.
- SETUP (SETUP_CYC): cs_n=0, addr valid; for writes data_out valid and oe=1.
- STROBE (STROBE_CYC): additionally r_n=0 (read) or w_n=0 (write). Reads: otg_hpi_data_in registered into the winner's rdata on the last STROBE cycle.
- HOLD (HOLD_CYC): strobe high; cs_n, addr, data, oe unchanged.
- RECOVER (RECOVER_CYC): cs_n=1, oe=0; winner's ack high during the first RECOVER cycle only. Then → IDLE.
- Requester contract: req dropped in the cycle after ack, or the request is counted as new. Changing we/addr/wdata while req is high and before grant is legal; changes after grant are ignored.
- Reads never drive oe; oe is never high while cs_n=1.
- Reset (any time, including mid-strobe): state=IDLE, cs_n=r_n=w_n=1, oe=0, addr=0, data_out=0, ack=0, rdata0=rdata1=0, last-grant=port 1 (port 0 wins the first tie). An interrupted access produces no ack.

## Timing
- All outputs registered; no combinational path from req to any HPI pin.
- Request seen in IDLE at cycle 0 → SETUP at cycle 1, ack at cycle 1+SETUP+STROBE+HOLD (defaults: cycle 5).
- Back-to-back period per access = 1+SETUP+STROBE+HOLD+RECOVER (defaults: 7 cycles).
- Tie in IDLE with alternating continuous requests → strict alternation, each port served at most every 2 periods.
- Strobe pulse exactly STROBE_CYC cycles; address and data stable from the first SETUP cycle through the last HOLD cycle.

## Structure
- Package hpi_pkg: state enum, HPI register constants (HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3), default timing constants.
- Sub-module hpi_rr_arbiter: 2-way round-robin grant from req and a last-grant register, updated only on the IDLE→SETUP transition.

## Test plan
- Port 0 write, addr=2 (ADDRESS), wdata=16'h052C, defaults → cs_n low cycles 1–4, w_n low cycles 2–3, oe high 1–4, data_out=16'h052C, ack[0] at cycle 5 only.
- Port 1 read, addr=0, data_in=16'hBEEF during strobe → r_n low 2–3, oe never high, rdata1=16'hBEEF with ack[1] at cycle 5, held after.
- Both req asserted at cycle 0 and kept across acks → grants 0,1,0,1; each ack one cycle; periods 7 cycles.
- Reset_reset_n pulsed low during STROBE of a write → all strobes high and oe low immediately, no ack; next request after reset completes normally.
- SETUP=3, STROBE=4, HOLD=2, RECOVER=1 → w_n low for exactly 4 cycles, ack at cycle 10, next IDLE at cycle 11.
- Requester holding req one cycle past ack → a second access is issued; verifies IDLE-only sampling.
